// File: rtl/pc_trace_pkg.sv
// rtl/pc_trace_pkg.sv - shared state encoding and default widths for the PC trace monitor
package pc_trace_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } pc_trace_state_e;

endpackage

// File: rtl/pc_hist_buf.sv
// rtl/pc_hist_buf.sv - circular history of recent distinct PCs with newest-first indexed read
module pc_hist_buf #(
  parameter int PC_W       = 32,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          push_i,
  input  logic [PC_W-1:0]               push_pc_i,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx_i,
  output logic [PC_W-1:0]               rd_pc_o,
  output logic                          rd_valid_o
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam logic [IDX_W:0] FILL_MAX = (IDX_W+1)'(HIST_DEPTH);

  logic [PC_W-1:0]  mem [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] rd_addr;
  logic [IDX_W:0]   fill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
    end
  end

  // Array contents are not reset; the fill count alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem[wr_ptr_q] <= push_pc_i;
  end

  assign rd_addr    = wr_ptr_q - IDX_W'(1) - rd_idx_i;
  assign rd_valid_o = ({1'b0, rd_idx_i} < fill_q);
  assign rd_pc_o    = rd_valid_o ? mem[rd_addr] : '0;

endmodule

// File: rtl/pc_trace_monitor.sv
// rtl/pc_trace_monitor.sv - PC observer with halt/timeout verdicts and change count
// History buffer is built only when PC_TRACE_HIST_EN is defined.
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HIST_DEPTH  = 8,
  parameter int HALT_CYCLES = 16,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [PC_W-1:0]               pc_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
  output logic [PC_W-1:0]               hist_pc_o,
  output logic                          hist_valid_o,
  output logic [CNT_W-1:0]              cycle_cnt_o,
  output logic [CNT_W-1:0]              change_cnt_o,
  output logic [1:0]                    state_o,
  output logic                          halt_o,
  output logic                          timeout_o,
  output logic                          done_o
);

  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0]    HALT_M1 = SW'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

  pc_trace_state_e  state_q, state_d;
  logic [PC_W-1:0]  pc_prev_q, pc_prev_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] change_q, change_d;
  logic             halt_q, halt_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             push;
  logic             halt_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_prev_q <= '0;
      stable_q  <= '0;
      cycle_q   <= '0;
      change_q  <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_prev_q <= pc_prev_d;
      stable_q  <= stable_d;
      cycle_q   <= cycle_d;
      change_q  <= change_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign halt_hit = en_i && (pc_i == pc_prev_q) && (stable_q == HALT_M1);

  always_comb begin
    state_d   = state_q;
    pc_prev_d = pc_prev_q;
    stable_d  = stable_q;
    cycle_d   = cycle_q;
    change_d  = change_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    push      = 1'b0;
    if (clr_i) begin
      state_d   = IDLE;
      pc_prev_d = '0;
      stable_d  = '0;
      cycle_d   = '0;
      change_d  = '0;
      halt_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            pc_prev_d = pc_i;
            push      = 1'b1;
            change_d  = CNT_W'(1);
            cycle_d   = CNT_W'(1);
            stable_d  = '0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (cycle_q != MAX_C) cycle_d = cycle_q + 1'b1;
          if (en_i) begin
            if (pc_i != pc_prev_q) begin
              push      = 1'b1;
              pc_prev_d = pc_i;
              stable_d  = '0;
              if (change_q != '1) change_d = change_q + 1'b1;
            end else begin
              stable_d = stable_q + 1'b1;
            end
          end
          // A halt landing on the budget edge takes precedence over the timeout.
          if (halt_hit) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (cycle_d == MAX_C) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    done_d = halt_d | timeout_d;
  end

  assign state_o      = state_q;
  assign cycle_cnt_o  = cycle_q;
  assign change_cnt_o = change_q;
  assign halt_o       = halt_q;
  assign timeout_o    = timeout_q;
  assign done_o       = done_q;

`ifdef PC_TRACE_HIST_EN
  pc_hist_buf #(
    .PC_W       (PC_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .push_i     (push),
    .push_pc_i  (pc_i),
    .rd_idx_i   (hist_idx_i),
    .rd_pc_o    (hist_pc_o),
    .rd_valid_o (hist_valid_o)
  );
`else
  logic unused_hist;
  assign unused_hist  = ^{push, hist_idx_i};
  assign hist_pc_o    = '0;
  assign hist_valid_o = 1'b0;
`endif

endmodule

// File: doc/pc_trace_monitor.md
# pc_trace_monitor

Parametrised program-counter observer for the RV32I cores, usable in simulation harnesses and as on-chip debug logic. It samples the core's PC, detects program termination (PC parked on a self-loop), enforces a cycle budget, counts PC changes, and keeps a circular history of the most recent distinct PCs. It sits beside `pipelined` and taps its PC debug output. A bench or debug bus reads the verdict and the trace.

## Interface
- `PC_W`, 32, PC width
- `CNT_W`, 32, width of cycle and change counters
- `HIST_DEPTH`, 8, history entries; power of two, ≥2
- `HALT_CYCLES`, 16, consecutive unchanged samples that declare halt; ≥2
- `MAX_CYCLES`, 100000, RUN-cycle budget before timeout; must fit in CNT_W

- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `pc_i` in PC_W: core PC
- `en_i` in 1: sample qualifier (low while core stalled)
- `clr_i` in 1: synchronous clear
- `hist_idx_i` in $clog2(HIST_DEPTH): 0 = newest entry
- `hist_pc_o` out PC_W: selected history entry
- `hist_valid_o` out 1: selected entry is populated
- `cycle_cnt_o` out CNT_W: cycles spent in RUN
- `change_cnt_o` out CNT_W: distinct-PC samples recorded
- `state_o` out 2: FSM state
- `halt_o`, `timeout_o`, `done_o` out 1: halt verdict, timeout verdict, halt|timeout

## Operation
- Reset: state IDLE, every counter 0, `pc_prev` 0, history empty, all outputs 0.
- IDLE: on `en_i`=1, load `pc_prev`=`pc_i`, push `pc_i`, set `change_cnt`=1, `cycle_cnt`=1, `stable_cnt`=0, and go to RUN.
- RUN: `cycle_cnt` increments every cycle, independent of `en_i`. Enabled samples are handled as follows:
  - `pc_i`≠`pc_prev`: push `pc_i`, increment `change_cnt` (saturating), clear `stable_cnt`, and update `pc_prev`.
  - `pc_i`==`pc_prev`: increment `stable_cnt`. When it reaches HALT_CYCLES, go to HALTED.
  - `en_i`=0: `stable_cnt` and `pc_prev` hold.
- Timeout: when `cycle_cnt` reaches MAX_CYCLES in RUN, go to TIMEOUT.
- Simultaneous halt and timeout in one cycle: HALTED wins.
- HALTED and TIMEOUT are sticky. Counters and history freeze. Only `clr_i` or reset leaves them.
- `clr_i` has priority over every event in every state. It returns the block to IDLE, zeroes the counters and empties the history; the array contents need not be cleared.
- History is a circular buffer:
  - Write pointer wraps modulo HIST_DEPTH.
  - Fill count saturates at HIST_DEPTH; the oldest entry is overwritten once full.
  - Read address is (wr_ptr − 1 − `hist_idx_i`) mod HIST_DEPTH.
  - If `hist_idx_i` ≥ fill count, the block outputs `hist_valid_o`=0 and `hist_pc_o`=0.
- Widths: `stable_cnt` is $clog2(HALT_CYCLES+1) bits. `cycle_cnt` stops at MAX_CYCLES.
- Encoding: `state_o` IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.

## Timing
- All state, counters and verdicts are registered.
- Verdict latency: `halt_o` rises on the edge that accepts the HALT_CYCLES-th equal sample. Condition and flag appear on the same edge, so there is no extra pipeline stage.
- `timeout_o` rises on the edge where `cycle_cnt` becomes MAX_CYCLES.
- `done_o` is a registered OR of the two verdicts, aligned with them.
- History read path is combinational from `hist_idx_i`, so data is valid in the same cycle.
- A push becomes visible at index 0 the cycle after its sampling edge.
- Reset mid-run takes effect immediately and asynchronously. Release is synchronous to the first rising `clk_i`.

## Configuration
- Macro `PC_TRACE_HIST_EN`.
- Defined: the history buffer and its read port are built as described above.
- Undefined: no storage is instantiated, and `hist_pc_o` and `hist_valid_o` are tied to 0. Counters, FSM and verdicts are unchanged.

## Structure
- Package `pc_trace_pkg` holds:
  - typedef `pc_trace_state_e`, a 2-bit enum with IDLE/RUN/HALTED/TIMEOUT
  - constants for the default PC_W and CNT_W
- Sub-module `pc_hist_buf` (parameters PC_W, HIST_DEPTH) owns the circular array, write pointer, fill count and indexed read.
- It is instantiated only under `PC_TRACE_HIST_EN`.

## Test plan
Common parameters: HIST_DEPTH=4, HALT_CYCLES=4, MAX_CYCLES=20.
- Reset: hold `rst_ni`=0 while `pc_i`=0x40 and `en_i`=1 → all outputs 0 and `state_o`=0. After release, the first enabled cycle gives `state_o`=1 and `change_cnt_o`=1.
- Halt: feed PCs 0x00, 0x04, 0x08, then 0x08 for four cycles → `halt_o`=1 after the 4th repeat, `change_cnt_o`=3, `done_o`=1. Verdict stays high as the PC moves on.
- Stall immunity: 0x10, then 0x10 with `en_i`=0 for 10 cycles → no halt. Three further enabled repeats → still no halt; a fourth → halt.
- Timeout: PC increments by 4 every cycle → `timeout_o`=1 once `cycle_cnt_o`=20, `halt_o`=0.
- History wrap: push 0x100, 0x104, 0x108, 0x10C, 0x110. Expect:
  - idx 0 → 0x110
  - idx 3 → 0x104
  - all four indices valid
  - after `clr_i`, idx 0 invalid and `state_o`=0
- Priority: the 4th equal sample lands on the cycle `cycle_cnt` hits 20 → HALTED, `timeout_o`=0. `clr_i` asserted together with a halt condition → IDLE.
